ex_muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_datapath.sv | 89 ++++++++
 rtl/ex_muldiv_unit.sv | 127 ++++++++++++
 tb/tb_ex_muldiv_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Opcodes, FSM state encoding and default datapath width.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative shift-add / restoring shift-subtract core with sign fix-up.
// One shared 2*WIDTH+1 accumulator serves both multiply and divide.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               div_q, div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;

    logic               sgn_op;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     t_sum, sh, diff;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo, rem;

    assign sgn_op = ~op[0];
    assign a_mag  = (sgn_op && a[WIDTH-1]) ? -a : a;
    assign b_mag  = (sgn_op && b[WIDTH-1]) ? -b : b;

    assign t_sum = acc_q[0] ? acc_q[2*WIDTH:WIDTH] + {1'b0, m_q}
                            : acc_q[2*WIDTH:WIDTH];
    assign sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign diff  = sh - {1'b0, m_q};

    // Operand load and one multiply or divide iteration per step
    always_comb begin
        acc_d  = acc_q;
        m_d    = m_q;
        div_d  = div_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        if (load) begin
            acc_d  = {{(WIDTH+1){1'b0}}, a_mag};
            m_d    = b_mag;
            div_d  = op[1];
            neg_d  = sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d = sgn_op & a[WIDTH-1];
        end else if (step) begin
            if (!div_q) begin
                acc_d = {1'b0, t_sum, acc_q[WIDTH-1:1]};
            end else if (!diff[WIDTH]) begin
                acc_d = {diff, acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {sh, acc_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Working registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            m_q    <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            m_q    <= m_d;
            div_q  <= div_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
        end
    end

    assign prod   = acc_q[2*WIDTH-1:0];
    assign prod_s = neg_q ? -prod : prod;
    assign quo    = acc_q[WIDTH-1:0];
    assign rem    = acc_q[2*WIDTH-1:WIDTH];

    assign res_hi = div_q ? (rneg_q ? -rem : rem) : prod_s[2*WIDTH-1:WIDTH];
    assign res_lo = div_q ? (neg_q ? -quo : quo) : prod_s[WIDTH-1:0];

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: FSM, iteration counter, HI/LO.
// Divide by zero skips the iterations and only pulses div_zero.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dzp_q, dzp_d;
    logic             dz_q, dz_d;
    logic             load, step, fix_we;
    logic [WIDTH-1:0] res_hi, res_lo;

    muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .op     (op),
        .a      (rs_val),
        .b      (rt_val),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // Next state, counter, HI/LO updates and handshake pulses
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load    = 1'b0;
        step    = 1'b0;
        fix_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mthi_we) hi_d = rs_val;
                if (mtlo_we) lo_d = rs_val;
                if (start && !flush) begin
                    if (op[1] && rt_val == '0) begin
                        state_d = FIX;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CW'(WIDTH);
                        dz_d    = 1'b0;
                        load    = 1'b1;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_d == '0) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                fix_we  = !flush;
                if (fix_we && !dz_q) begin
                    hi_d = res_hi;
                    lo_d = res_lo;
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = fix_we;
        dzp_d  = fix_we & dz_q;
        busy_d = (state_d != IDLE) && !(state_d == FIX && dz_d);
    end

    // Architectural and control state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dzp_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dzp_q   <= dzp_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dzp_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: arithmetic/timing model plus
// directed vectors with literal expected HI/LO values.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush, mthi_we, mtlo_we;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .flush    (flush),
        .mthi_we  (mthi_we),
        .mtlo_we  (mtlo_we),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: expected result by plain 64-bit arithmetic
    function automatic logic [63:0] calc(input logic [1:0] o,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: p = 64'(sa * sb);
            2'b01: p = {32'd0, a} * {32'd0, b};
            2'b10: begin
                q = sa / sb;
                r = sa % sb;
                p = {r[31:0], q[31:0]};
            end
            default: p = {a % b, a / b};
        endcase
        return p;
    endfunction

    int          m_rem;
    logic        m_pdz, m_busy, m_done, m_dz;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;

    // Model: cycles-to-completion countdown, 33 edges per op
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_rem = 0; m_pdz = 0; m_busy = 0; m_done = 0; m_dz = 0;
            m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0;
        end else begin
            m_done = 0;
            m_dz   = 0;
            if (m_rem > 0) begin
                if (flush) begin
                    m_rem = 0;
                end else begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_done = 1;
                        m_dz   = m_pdz;
                        if (!m_pdz) begin
                            m_hi = m_phi;
                            m_lo = m_plo;
                        end
                    end
                end
            end else begin
                if (mthi_we) m_hi = rs_val;
                if (mtlo_we) m_lo = rs_val;
                if (start && !flush) begin
                    if (op[1] && rt_val == 0) begin
                        m_pdz = 1;
                        m_rem = 1;
                    end else begin
                        m_pdz = 0;
                        m_rem = 33;
                        {m_phi, m_plo} = calc(op, rs_val, rt_val);
                    end
                end
            end
            m_busy = (m_rem > 0) && !m_pdz;
        end
    end

    // Compare every cycle against the model
    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("div_zero", 64'(div_zero), 64'(m_dz));
        chk("hi", 64'(hi), 64'(m_hi));
        chk("lo", 64'(lo), 64'(m_lo));
    end

    always @(posedge clk)
        if (rst) assert (!(start && busy)) else $error("start while busy");

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input int ebusy,
                          input logic edz);
        int nb;
        logic seen;
        op = o; rs_val = a; rt_val = b; start = 1;
        cyc();
        start = 0;
        nb = 0;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) nb++;
            cyc();
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("dz_pulse", 64'(div_zero), 64'(edz));
        chk("hi_lit", 64'(hi), 64'(ehi));
        chk("lo_lit", 64'(lo), 64'(elo));
        chk("busy_cycles", 64'(nb), 64'(ebusy));
        cyc();
        chk("done_once", 64'(done), 64'd0);
    endtask

    initial begin
        rst = 0; start = 0; flush = 0; mthi_we = 0; mtlo_we = 0;
        op = 0; rs_val = 0; rt_val = 0;
        cyc(); cyc();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        rst = 1;
        cyc();

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 33, 0);
        run_op(2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 0);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 0);
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33, 0);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, 0);
        run_op(2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33, 0);

        rs_val = 32'h1234; mthi_we = 1;
        cyc();
        mthi_we = 0; rs_val = 32'h5678; mtlo_we = 1;
        cyc();
        mtlo_we = 0;
        chk("mthi", 64'(hi), 64'h1234);
        chk("mtlo", 64'(lo), 64'h5678);
        run_op(2'b11, 32'd55, 32'd0, 32'h1234, 32'h5678, 0, 1);

        op = 2'b00; rs_val = 5; rt_val = 6; start = 1;
        cyc();
        start = 0;
        repeat (9) cyc();
        flush = 1;
        cyc();
        flush = 0;
        chk("flush_busy", 64'(busy), 64'd0);
        repeat (40) cyc();
        chk("flush_hi", 64'(hi), 64'h1234);
        chk("flush_lo", 64'(lo), 64'h5678);
        run_op(2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 33, 0);

        op = 2'b11; rs_val = 1000; rt_val = 3; start = 1;
        cyc();
        start = 0;
        repeat (5) cyc();
        #2 rst = 0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        cyc();
        rst = 1;
        cyc();
        run_op(2'b11, 32'd9, 32'd3, 32'd0, 32'd3, 33, 0);

        repeat (3) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
